// File: rtl/ram_sp_if.sv
// Request/response bus of the single-port RAM controller.
// The rsp_perr wire exists only when RAM_PARITY_EN is defined.
interface ram_sp_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
`ifdef RAM_PARITY_EN
  logic                  rsp_perr;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_perr
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_perr
  );
`else
  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
`endif
endinterface

// File: rtl/ram_sp_ctrl.sv
// Single-port RAM with one-word-per-cycle clear sweep and valid/ready requests.
// Optional macro RAM_PARITY_EN adds a stored even-parity bit and rsp_perr.
module ram_sp_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic   clk,
  input  logic   reset,
  ram_sp_if.slave bus,
  input  logic   clear_start,
  output logic   busy,
  output logic   clear_done
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef RAM_PARITY_EN
  localparam int WORD_W = DATA_WIDTH + 1;
`else
  localparam int WORD_W = DATA_WIDTH;
`endif

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_addr, clr_addr_nxt;
  logic                  ready_nxt, busy_nxt, done_nxt;

  logic [WORD_W-1:0]     mem [DEPTH];
  logic                  hs, rd_hs, mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [WORD_W-1:0]     mem_wword, rd_word;

  function automatic logic [WORD_W-1:0] pack_word(input logic [DATA_WIDTH-1:0] d);
`ifdef RAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  assign hs    = bus.req_valid && bus.req_ready;
  assign rd_hs = hs && !bus.req_write;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= CLEAR;
      clr_addr      <= '0;
      bus.req_ready <= 1'b0;
      busy          <= 1'b1;
      clear_done    <= 1'b0;
    end else begin
      state         <= state_nxt;
      clr_addr      <= clr_addr_nxt;
      bus.req_ready <= ready_nxt;
      busy          <= busy_nxt;
      clear_done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    ready_nxt    = bus.req_ready;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    case (state)
      CLEAR: begin
        // Address holds at DEPTH-1 on the final sweep edge rather than wrapping.
        if (clr_addr == '1) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          ready_nxt = 1'b1;
          done_nxt  = 1'b1;
        end else begin
          clr_addr_nxt = clr_addr + 1'b1;
        end
      end
      IDLE: begin
        if (clear_start) begin
          state_nxt    = CLEAR;
          clr_addr_nxt = '0;
          ready_nxt    = 1'b0;
          busy_nxt     = 1'b1;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // One shared write port: sweep in CLEAR, accepted writes in IDLE.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.req_addr;
    mem_wword = pack_word(bus.req_wdata);
    if (state == CLEAR) begin
      mem_we    = reset;
      mem_waddr = clr_addr;
      mem_wword = '0;
    end else if (hs && bus.req_write) begin
      mem_we = reset;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wword;
  end

  assign rd_word = mem[bus.req_addr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
`ifdef RAM_PARITY_EN
      bus.rsp_perr  <= 1'b0;
`endif
    end else begin
      bus.rsp_valid <= rd_hs;
      if (rd_hs) begin
        bus.rsp_rdata <= rd_word[DATA_WIDTH-1:0];
`ifdef RAM_PARITY_EN
        bus.rsp_perr  <= ^rd_word;
`endif
      end
    end
  end
endmodule
